// File: rtl/jump_enc_pkg.sv
// Shared types and constants for the J-type jump target encoder.
// Entry layout is {instr, err}; both the queue and the top level use it.
package jump_enc_pkg;

   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;

   localparam int ERR_ALIGN  = 0;
   localparam int ERR_REGION = 1;

   localparam int CNT_W = 16;

   typedef struct packed {
      logic [31:0] instr;
      logic [1:0]  err;
   } entry_t;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/jump_enc_fifo.sv
// Small pointer-based FIFO of encoded {instr, err} entries.
// Head is read straight from storage, so it cannot change until popped.
module jump_enc_fifo
   import jump_enc_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  logic   pop,
   input  entry_t wr_data,
   output entry_t rd_data,
   output logic   full,
   output logic   empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_BITS = $clog2(DEPTH + 1);

   entry_t              mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_BITS-1:0] count;
   logic                do_push;
   logic                do_pop;

   assign full    = (count == CNT_BITS'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/jump_target_encoder.sv
// Turns an absolute jump target into a J-type word {opcode, target[27:2]},
// flagging targets the jump-address composer could not reproduce.
module jump_target_encoder
   import jump_enc_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      pc_i,
   input  logic [31:0]      target_i,
   input  logic             link_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [31:0]      instr_o,
   output logic [1:0]       err_o,
   output logic [CNT_W-1:0] jump_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   entry_t     req;
   entry_t     head;
   logic [3:0] region;
   logic       full;
   logic       empty;
   logic       accept;

   // The composer takes the upper nibble from PC+4, which may carry out of PC.
   assign region = 4'((pc_i + 32'd4) >> 28);

   always_comb begin
      req                 = '0;
      req.instr           = {(link_i ? OP_JAL : OP_J), target_i[27:2]};
      req.err[ERR_ALIGN]  = (target_i[1:0] != 2'b00);
      req.err[ERR_REGION] = (target_i[31:28] != region);
   end

   assign accept      = in_valid_i && !full;
   assign in_ready_o  = !full;
   assign out_valid_o = !empty;
   assign instr_o     = head.instr;
   assign err_o       = head.err;

   jump_enc_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk_i),
      .rst_n   (rst_i),
      .push    (accept),
      .pop     (out_ready_i),
      .wr_data (req),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         jump_cnt_o <= '0;
         err_cnt_o  <= '0;
      end else if (accept) begin
         jump_cnt_o <= sat_inc(jump_cnt_o);
         if (req.err != 2'b00) err_cnt_o <= sat_inc(err_cnt_o);
      end
   end

endmodule
